// File: rtl/serial_paralelo_rx.sv
// Receive-side deserializer: hunts for COM byte alignment, declares the link active
// after BC_COUNT aligned COMs, then presents each non-COM byte with valid/idle qualifiers.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM      = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active_out,
  output logic       idle_out,
  output logic       byte_stb
);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  state_t     state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic [7:0] nb;
  logic       boundary;

  // nb is the byte that completes on this edge, including the bit being sampled now
  assign nb       = {sr[6:0], data_in};
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state      <= SEARCH;
      sr         <= 8'h00;
      bit_cnt    <= 3'd0;
      bc_cnt     <= 4'd0;
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
      idle_out   <= 1'b0;
      byte_stb   <= 1'b0;
    end else begin
      sr       <= nb;
      byte_stb <= 1'b0;
      case (state)
        SEARCH: begin
          if (nb == COM) begin
            bit_cnt <= 3'd0;
            bc_cnt  <= 4'd1;
            if (BC_TARGET == 4'd1) begin
              state      <= ACTIVE;
              active_out <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (nb == COM) begin
              bc_cnt <= bc_cnt + 4'd1;
              if (bc_cnt + 4'd1 == BC_TARGET) begin
                state      <= ACTIVE;
                active_out <= 1'b1;
              end
            end else begin
              // a broken COM run means the phase guess was wrong; hunt again from the next bit
              bc_cnt <= 4'd0;
              state  <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            byte_stb <= 1'b1;
            if (nb == COM) begin
              valid_out <= 1'b0;
              idle_out  <= 1'b1;
            end else begin
              data_out  <= nb;
              valid_out <= 1'b1;
              idle_out  <= 1'b0;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed scenarios plus random byte streams, every edge
// compared against a byte-phase reference model built on absolute edge positions.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM      = 8'hBC;
  localparam int         BC_COUNT = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active_out;
  logic       idle_out;
  logic       byte_stb;

  int vectors     = 0;
  int miscompares = 0;

  typedef enum {M_HUNT, M_ALIGN, M_LOCKED} mode_t;
  mode_t      m_mode   = M_HUNT;
  longint     m_edge   = 0;
  longint     m_anchor = 0;
  int         m_run    = 0;
  logic [7:0] m_win    = 8'h00;
  logic [7:0] e_data   = 8'h00;
  logic       e_valid  = 1'b0;
  logic       e_active = 1'b0;
  logic       e_idle   = 1'b0;
  logic       e_stb    = 1'b0;

  serial_paralelo_rx #(.COM(COM), .BC_COUNT(BC_COUNT)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active_out(active_out),
    .idle_out  (idle_out),
    .byte_stb  (byte_stb)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte boundaries are every 8th edge after the edge where alignment was first found
  task automatic modelEdge(input logic b, input logic r);
    logic on_boundary;
    m_edge++;
    e_stb = 1'b0;
    if (!r) begin
      m_win    = 8'h00;
      m_mode   = M_HUNT;
      m_run    = 0;
      m_anchor = m_edge;
      e_data   = 8'h00;
      e_valid  = 1'b0;
      e_active = 1'b0;
      e_idle   = 1'b0;
    end else begin
      m_win       = {m_win[6:0], b};
      on_boundary = ((m_edge - m_anchor) % 8 == 0);
      case (m_mode)
        M_HUNT: if (m_win == COM) begin
          m_anchor = m_edge;
          m_run    = 1;
          if (m_run == BC_COUNT) begin
            m_mode   = M_LOCKED;
            e_active = 1'b1;
          end else begin
            m_mode = M_ALIGN;
          end
        end
        M_ALIGN: if (on_boundary) begin
          if (m_win == COM) begin
            m_run++;
            if (m_run == BC_COUNT) begin
              m_mode   = M_LOCKED;
              e_active = 1'b1;
            end
          end else begin
            m_run  = 0;
            m_mode = M_HUNT;
          end
        end
        M_LOCKED: if (on_boundary) begin
          e_stb = 1'b1;
          if (m_win == COM) begin
            e_valid = 1'b0;
            e_idle  = 1'b1;
          end else begin
            e_data  = m_win;
            e_valid = 1'b1;
            e_idle  = 1'b0;
          end
        end
        default: m_mode = M_HUNT;
      endcase
    end
  endtask

  task automatic sendBit(input logic b, input logic r);
    data_in = b;
    reset   = r;
    @(posedge clk_32f);
    modelEdge(b, r);
    @(negedge clk_32f);
    checkOutput("data_out", data_out, e_data);
    checkOutput("valid_out", 8'(valid_out), 8'(e_valid));
    checkOutput("active_out", 8'(active_out), 8'(e_active));
    checkOutput("idle_out", 8'(idle_out), 8'(e_idle));
    checkOutput("byte_stb", 8'(byte_stb), 8'(e_stb));
  endtask

  task automatic applyStimulus(input logic [7:0] bv);
    for (int i = 7; i >= 0; i--) sendBit(bv[i], 1'b1);
  endtask

  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) sendBit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    logic [7:0] t6_bytes [4];
    logic [7:0] t6_data  [4];
    logic       t6_valid [4];
    logic [7:0] bv;
    t6_bytes = '{8'h00, 8'hFF, 8'hBC, 8'h01};
    t6_data  = '{8'h00, 8'hFF, 8'hFF, 8'h01};
    t6_valid = '{1'b1, 1'b1, 1'b0, 1'b1};

    // reset state and an incomplete COM run
    applyReset(3);
    checkOutput("t1_rst_data", data_out, 8'h00);
    checkOutput("t1_rst_active", 8'(active_out), 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(COM);
    applyStimulus(8'h55);
    checkOutput("t1_active", 8'(active_out), 8'h00);

    // basic lock
    applyReset(2);
    for (int i = 0; i < 3; i++) applyStimulus(COM);
    checkOutput("t2_pre_active", 8'(active_out), 8'h00);
    applyStimulus(COM);
    checkOutput("t2_active", 8'(active_out), 8'h01);
    applyStimulus(8'hA5);
    checkOutput("t2_data", data_out, 8'hA5);
    checkOutput("t2_valid", 8'(valid_out), 8'h01);
    checkOutput("t2_idle", 8'(idle_out), 8'h00);
    checkOutput("t2_stb", 8'(byte_stb), 8'h01);

    // misaligned start
    applyReset(2);
    for (int i = 0; i < 3; i++) sendBit(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(COM);
    applyStimulus(8'h3C);
    checkOutput("t3_data", data_out, 8'h3C);
    checkOutput("t3_valid", 8'(valid_out), 8'h01);
    applyStimulus(COM);
    checkOutput("t3_idle_valid", 8'(valid_out), 8'h00);
    checkOutput("t3_idle", 8'(idle_out), 8'h01);
    checkOutput("t3_idle_data", data_out, 8'h3C);

    // alignment abort
    applyReset(2);
    applyStimulus(COM);
    applyStimulus(COM);
    applyStimulus(8'h12);
    checkOutput("t4_abort_active", 8'(active_out), 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(COM);
    checkOutput("t4_active", 8'(active_out), 8'h01);
    applyStimulus(8'h77);
    checkOutput("t4_data", data_out, 8'h77);

    // reset in the middle of 0x99 while active
    bv = 8'h99;
    for (int i = 7; i >= 4; i--) sendBit(bv[i], 1'b1);
    sendBit(bv[3], 1'b0);
    checkOutput("t5_rst_active", 8'(active_out), 8'h00);
    checkOutput("t5_rst_data", data_out, 8'h00);
    for (int i = 2; i >= 0; i--) sendBit(bv[i], 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(COM);
    checkOutput("t5_relock", 8'(active_out), 8'h01);
    applyStimulus(8'h5A);
    checkOutput("t5_data", data_out, 8'h5A);

    // back-to-back data including 0x00, 0xFF and an idle slot
    for (int i = 0; i < 4; i++) begin
      applyStimulus(t6_bytes[i]);
      checkOutput("t6_data", data_out, t6_data[i]);
      checkOutput("t6_valid", 8'(valid_out), 8'(t6_valid[i]));
      checkOutput("t6_stb", 8'(byte_stb), 8'h01);
    end

    // random streams: junk phase, variable COM run, mixed bytes, rare resets
    for (int it = 0; it < 30; it++) begin
      applyReset(1 + $urandom_range(0, 2));
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) sendBit(1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) applyStimulus(COM);
      for (int k = 0; k < 8; k++) begin
        bv = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom_range(0, 255));
        for (int i = 7; i >= 0; i--) sendBit(bv[i], 1'($urandom_range(0, 299) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
